// File: rtl/frame_wr_feeder.sv
// Host-pixel write feeder: a small FIFO toward the SDRAM controller plus write-address generation.
// Optional FRAME_WR_FEEDER_PAGE_FLIP_EN: flip page_set bit 0 on every frame wrap (double buffering).
module frame_wr_feeder #(
    parameter int DEPTH = 8,
    parameter int H_ACT = 800,
    parameter int V_ACT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] px_data,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic        frame_start,
    input  logic [2:0]  page_sel,
    output logic [2:0]  page_set,
    output logic [8:0]  row_add_user,
    output logic [9:0]  col_add_user,
    output logic        FIFO_full,
    output logic [15:0] FIFO_out,
    input  logic        startup_inc,
    input  logic        FIFO_RD_req,
    output logic        frame_done,
    output logic        underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   mem [DEPTH];

    logic push;
    logic pop;
    logic col_last;
    logic row_last;
    logic wrap;

    assign px_ready  = (count < CW'(DEPTH));
    assign FIFO_full = (count != '0);
    assign FIFO_out  = mem[rd_ptr];

    // frame_start flushes the FIFO, so it masks any coincident push or pop
    assign push = px_valid & px_ready & ~frame_start;
    assign pop  = FIFO_RD_req & FIFO_full & ~frame_start;

    assign col_last = (col_add_user == 10'(H_ACT - 1));
    assign row_last = (row_add_user == 9'(V_ACT - 1));
    assign wrap     = startup_inc & col_last & row_last & ~frame_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            underflow <= 1'b0;
        end else if (frame_start) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (FIFO_RD_req && !FIFO_full) underflow <= 1'b1;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= px_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_add_user <= '0;
            row_add_user <= '0;
        end else if (frame_start) begin
            col_add_user <= '0;
            row_add_user <= '0;
        end else if (startup_inc) begin
            if (col_last) begin
                col_add_user <= '0;
                row_add_user <= row_last ? 9'd0 : row_add_user + 1'b1;
            end else begin
                col_add_user <= col_add_user + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done <= 1'b0;
            page_set   <= '0;
        end else begin
            frame_done <= wrap;
            if (frame_start) begin
                page_set <= page_sel;
            end
`ifdef FRAME_WR_FEEDER_PAGE_FLIP_EN
            else if (wrap) begin
                page_set <= page_set ^ 3'b001;
            end
`endif
        end
    end

endmodule

// File: doc/frame_wr_feeder.md
FRAME_WR_FEEDER -- requirements
Module: frame_wr_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 16-bit words (power of 2, 4..32).
REQ-002 SHALL have parameter H_ACT, default 800, active pixels per line.
REQ-003 SHALL have parameter V_ACT, default 480, active lines per frame.
REQ-004 clk  input  1  system clock (same clock as the SDRAM/TFT controller).
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 px_data  input  16  host pixel, RGB565.
REQ-007 px_valid  input  1  host pixel valid.
REQ-008 px_ready  output  1  feeder can accept a pixel this cycle.
REQ-009 frame_start  input  1  one-cycle pulse; restarts the write frame.
REQ-010 page_sel  input  3  host-selected SDRAM page, sampled on frame_start.
REQ-011 page_set  output  3  SDRAM write page for the controller.
REQ-012 row_add_user  output  9  SDRAM write row (0..V_ACT-1).
REQ-013 col_add_user  output  10  SDRAM write column (0..H_ACT-1).
REQ-014 FIFO_full  output  1  high when the FIFO holds at least one word (data-available).
REQ-015 FIFO_out  output  16  head-of-FIFO word, valid while FIFO_full=1.
REQ-016 startup_inc  input  1  controller pulse: the word at the current address has been written.
REQ-017 FIFO_RD_req  input  1  controller pulse: pop the head word.
REQ-018 frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-019 underflow  output  1  sticky error flag.

Function
REQ-020 SHALL implement a DEPTH-word synchronous FIFO with a log2(DEPTH)+1-bit occupancy counter and wrapping read/write pointers.
REQ-021 px_ready SHALL equal (count < DEPTH), combinationally from registered state.
REQ-022 A push SHALL occur when px_valid & px_ready; px_data is written at the write pointer on that clk edge.
REQ-023 A pop SHALL occur when FIFO_RD_req & (count != 0); FIFO_out SHALL present the new head word on the following cycle.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; when count==DEPTH, px_ready=0 in that cycle and only the pop occurs.
REQ-025 FIFO_RD_req with count==0 SHALL be ignored and SHALL set underflow, which is cleared only by reset.
REQ-026 FIFO_full SHALL be (count != 0), combinationally from registered state.
REQ-027 On startup_inc, col_add_user SHALL increment; on H_ACT-1 it SHALL wrap to 0 and row_add_user SHALL increment.
REQ-028 On startup_inc at col H_ACT-1, row V_ACT-1: both counters SHALL wrap to 0, and frame_done SHALL pulse high on the next cycle for exactly one cycle.
REQ-029 On frame_start: both counters SHALL clear, the FIFO SHALL flush (count=0, pointers=0), page_set SHALL load page_sel, and a push in the same cycle SHALL be discarded.
REQ-030 frame_start SHALL take priority over startup_inc, FIFO_RD_req and a coincident frame wrap; frame_done SHALL NOT pulse in that case.
REQ-031 Address counters SHALL change only on startup_inc or frame_start, never on a push or pop.

Reset
REQ-032 While rst=0: count, pointers, counters, page_set=0, frame_done=0, underflow=0; px_ready=1, FIFO_full=0.
REQ-033 FIFO storage SHALL NOT be reset; FIFO_out is don't-care while FIFO_full=0.
REQ-034 Reset deassertion SHALL be synchronized in the design's usual way; the first push is accepted on the first clk edge after release.

Configuration
REQ-035 Macro FRAME_WR_FEEDER_PAGE_FLIP_EN: when defined, on every frame wrap (REQ-028) page_set SHALL toggle bit 0 (page_set ^ 3'b001), giving double buffering without host action.
REQ-036 Without FRAME_WR_FEEDER_PAGE_FLIP_EN, page_set SHALL change only on frame_start (and reset).

Verification
REQ-037 Reset, push 0x1234, 0xABCD -> FIFO_full=1 one cycle after the first push, FIFO_out=0x1234; FIFO_RD_req -> FIFO_out=0xABCD next cycle.
REQ-038 Push 8 words with no pops (DEPTH=8) -> px_ready=0 after the 8th; a 9th px_valid is not stored; pop+valid in the same cycle -> count stays 7 after pop then refill.
REQ-039 Pulse startup_inc 800 times from (0,0) -> col=0, row=1; 384000 pulses -> row=0, col=0, one frame_done pulse.
REQ-040 FIFO_RD_req with the FIFO empty -> no pointer change, underflow=1 until rst.
REQ-041 frame_start with page_sel=5 at row 100, col 37, 3 words queued -> row=0, col=0, FIFO_full=0, page_set=5 next cycle.
REQ-042 With FRAME_WR_FEEDER_PAGE_FLIP_EN, page_set=2, complete one frame -> page_set=3; a second frame -> page_set=2; without the macro -> stays 2.
